iterative_multiplier: RTL and testbench

- Parametrised multi-cycle multiplier/multiply-accumulate unit for the execute stage. It replaces the single-cycle multiply path.
- Supports MUL, MLA, UMULL, UMLAL, SMULL and SMLAL with correct signed semantics, configurable datapath width and radix (bits consumed per cycle).
- Uses a start/busy/done handshake and a pipeline flush, so the core can stall or cancel cleanly.

---
 rtl/iterative_multiplier_if.sv | 21 ++
 rtl/iterative_multiplier.sv | 135 +++++++++++++
 tb/tb_iterative_multiplier.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/iterative_multiplier_if.sv
// Request/response bundle between the execute stage and the iterative multiplier.
// The master drives the operation request; the slave is the multiplier itself.
interface iterative_multiplier_if #(parameter int WIDTH = 32);
    logic                 start;
    logic                 flush;
    logic [2:0]           op_type;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     c;
    logic [WIDTH-1:0]     d;
    logic [2*WIDTH-1:0]   result;
    logic                 flag_n;
    logic                 flag_z;
    logic                 busy;
    logic                 done;

    modport master (output start, flush, op_type, a, b, c, d,
                    input  result, flag_n, flag_z, busy, done);
    modport slave  (input  start, flush, op_type, a, b, c, d,
                    output result, flag_n, flag_z, busy, done);
endinterface

// File: rtl/iterative_multiplier.sv
// Multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit, BITS_PER_CYCLE multiplier bits per CALC edge.
// Optional MUL_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module iterative_multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 2
) (
    input logic                  clk,
    input logic                  n_reset,
    iterative_multiplier_if.slave bus
);
    localparam int K  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(K + 1);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

    state_t          state;
    logic [W2-1:0]   mcand;
    logic [W2-1:0]   acc;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] d_q;
    logic [2:0]      op_q;
    logic            sign_q;
    logic [CW-1:0]   cnt;
    logic [W2-1:0]   result_q;
    logic            flag_n_q;
    logic            flag_z_q;
    logic            busy_q;
    logic            done_q;

    // Operand magnitudes at the start edge; only SMULL/SMLAL are signed.
    logic            signed_op;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    assign signed_op = (bus.op_type[2:1] == 2'b11);
    assign mag_a     = (signed_op && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign mag_b     = (signed_op && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    logic [W2-1:0] pp;
    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++)
            if (mplier[i]) pp = pp + (mcand << i);
    end

    logic last_iter;
`ifdef MUL_EARLY_TERM_EN
    assign last_iter = (cnt == CW'(1)) || ((mplier >> BITS_PER_CYCLE) == '0);
`else
    assign last_iter = (cnt == CW'(1));
`endif

    // Sign fix-up and accumulate; every sum wraps at 2*WIDTH bits, so a
    // two's-complement {c,d} needs no special handling beyond plain addition.
    logic          long_op;
    logic [W2-1:0] prod;
    logic [W2-1:0] addend;
    logic [W2-1:0] sum;
    logic [W2-1:0] res_final;
    assign long_op = op_q[2];
    assign prod    = sign_q ? (~acc + 1'b1) : acc;
    always_comb begin
        addend = '0;
        case (op_q)
            3'b001:         addend = {{WIDTH{1'b0}}, c_q};
            3'b101, 3'b111: addend = {c_q, d_q};
            default:        addend = '0;
        endcase
    end
    assign sum       = prod + addend;
    assign res_final = long_op ? sum : {{WIDTH{1'b0}}, sum[WIDTH-1:0]};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state    <= IDLE;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            c_q      <= '0;
            d_q      <= '0;
            op_q     <= '0;
            sign_q   <= 1'b0;
            cnt      <= '0;
            result_q <= '0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state  <= IDLE;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.start) begin
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mplier <= mag_b;
                        c_q    <= bus.c;
                        d_q    <= bus.d;
                        op_q   <= bus.op_type;
                        sign_q <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        acc    <= '0;
                        cnt    <= CW'(K);
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end
                    CALC: begin
                        acc    <= acc + pp;
                        mcand  <= mcand << BITS_PER_CYCLE;
                        mplier <= mplier >> BITS_PER_CYCLE;
                        cnt    <= cnt - 1'b1;
                        if (last_iter) state <= FINAL;
                    end
                    FINAL: begin
                        result_q <= res_final;
                        flag_n_q <= long_op ? res_final[W2-1] : res_final[WIDTH-1];
                        flag_z_q <= long_op ? (res_final == '0) : (res_final[WIDTH-1:0] == '0);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.result = result_q;
    assign bus.flag_n = flag_n_q;
    assign bus.flag_z = flag_z_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed bench for iterative_multiplier (WIDTH=32, BITS_PER_CYCLE=2).
module tb_iterative_multiplier;
    logic clk;
    logic n_reset;
    int   n_cmp;
    int   n_bad;

    iterative_multiplier_if #(.WIDTH(32)) bus ();

    iterative_multiplier #(.WIDTH(32), .BITS_PER_CYCLE(2)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request so that it is sampled at the next rising edge (T0); returns #1 after T0.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
        @(negedge clk);
        bus.op_type = op; bus.a = a; bus.b = b; bus.c = c; bus.d = d;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h1234_5678; bus.c = 32'h5555_5555; bus.d = 32'hAAAA_AAAA;
    endtask

    // Count edges after T0 until done is seen; busy_ok drops if busy was low before done.
    task automatic wait_done(output int edges, output logic got, output logic busy_ok);
        edges = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && edges < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            edges++;
            if (bus.done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus.result !== 64'd0) begin n_bad++; $display("FAIL reset_result got=%h exp=0", bus.result); end
        n_cmp++; if ({bus.flag_n, bus.flag_z} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got=%b exp=00", {bus.flag_n, bus.flag_z}); end
        n_cmp++; if ({bus.busy, bus.done} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done got=%b exp=00", {bus.busy, bus.done}); end
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic test_mul;
        int e; logic g, bo;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'd0, 32'd0);
        wait_done(e, g, bo);
        n_cmp++; if (e != 17) begin n_bad++; $display("FAIL mul_latency got=%0d exp=17", e); end
        n_cmp++; if (bo !== 1'b1) begin n_bad++; $display("FAIL mul_busy got=%b exp=1", bo); end
        n_cmp++; if (bus.result !== 64'h0000_0000_FFFF_FFEB) begin n_bad++; $display("FAIL mul_result got=%h exp=00000000ffffffeb", bus.result); end
        n_cmp++; if ({bus.flag_n, bus.flag_z} !== 2'b10) begin n_bad++; $display("FAIL mul_flags got=%b exp=10", {bus.flag_n, bus.flag_z}); end
        @(posedge clk); #1;
        n_cmp++; if ({bus.done, bus.busy} !== 2'b00) begin n_bad++; $display("FAIL mul_done_pulse got=%b exp=00", {bus.done, bus.busy}); end
    endtask

    task automatic test_long;
        int e; logic g, bo;
        issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        wait_done(e, g, bo);
        n_cmp++; if (g !== 1'b1 || bus.result !== 64'hFFFF_FFFE_0000_0001) begin n_bad++; $display("FAIL umull_result got=%h exp=fffffffe00000001", bus.result); end
        n_cmp++; if ({bus.flag_n, bus.flag_z} !== 2'b10) begin n_bad++; $display("FAIL umull_flags got=%b exp=10", {bus.flag_n, bus.flag_z}); end
        issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        wait_done(e, g, bo);
        n_cmp++; if (g !== 1'b1 || bus.result !== 64'h0000_0000_0000_0001) begin n_bad++; $display("FAIL smull_result got=%h exp=0000000000000001", bus.result); end
        n_cmp++; if ({bus.flag_n, bus.flag_z} !== 2'b00) begin n_bad++; $display("FAIL smull_flags got=%b exp=00", {bus.flag_n, bus.flag_z}); end
    endtask

    task automatic test_accumulate;
        int e; logic g, bo;
        issue(3'b111, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd10);
        wait_done(e, g, bo);
        n_cmp++; if (g !== 1'b1 || bus.result !== 64'd4) begin n_bad++; $display("FAIL smlal_result got=%h exp=0000000000000004", bus.result); end
        issue(3'b001, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0);
        wait_done(e, g, bo);
        n_cmp++; if (g !== 1'b1 || bus.result !== 64'd0) begin n_bad++; $display("FAIL mla_result got=%h exp=0", bus.result); end
        n_cmp++; if ({bus.flag_n, bus.flag_z} !== 2'b01) begin n_bad++; $display("FAIL mla_flags got=%b exp=01", {bus.flag_n, bus.flag_z}); end
        // MLA with non-zero addend: 6*7 + 100 = 142
        issue(3'b001, 32'd6, 32'd7, 32'd100, 32'hFFFF_FFFF);
        wait_done(e, g, bo);
        n_cmp++; if (g !== 1'b1 || bus.result !== 64'd142) begin n_bad++; $display("FAIL mla_addend got=%h exp=8e", bus.result); end
        // UMLAL: 2*3 + {1, 0xFFFFFFFF} = 0x2_00000005
        issue(3'b101, 32'd2, 32'd3, 32'd1, 32'hFFFF_FFFF);
        wait_done(e, g, bo);
        n_cmp++; if (g !== 1'b1 || bus.result !== 64'h0000_0002_0000_0005) begin n_bad++; $display("FAIL umlal_result got=%h exp=0000000200000005", bus.result); end
    endtask

    task automatic test_start_while_busy;
        int e; logic g, bo;
        issue(3'b100, 32'd3, 32'd4, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.op_type = 3'b000; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(e, g, bo);
        n_cmp++; if (g !== 1'b1 || bus.result !== 64'd12) begin n_bad++; $display("FAIL busy_start_result got=%h exp=c", bus.result); end
        g = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (bus.done === 1'b1 || bus.busy === 1'b1) g = 1'b1; end
        n_cmp++; if (g !== 1'b0) begin n_bad++; $display("FAIL busy_start_extra_op got=%b exp=0", g); end
    endtask

    task automatic test_flush;
        logic seen;
        issue(3'b000, 32'd100, 32'hFFFF_FFFF, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got=%b exp=0", bus.busy); end
        seen = 1'b0;
        repeat (25) begin @(posedge clk); #1; if (bus.done === 1'b1) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_done got=%b exp=0", seen); end
        n_cmp++; if (bus.result !== 64'd12 || {bus.flag_n, bus.flag_z} !== 2'b00) begin n_bad++; $display("FAIL flush_result got=%h exp=c", bus.result); end
        // start and flush together in IDLE: request is dropped
        @(negedge clk);
        bus.op_type = 3'b000; bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_flush_busy got=%b exp=0", bus.busy); end
        seen = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0 || bus.result !== 64'd12) begin n_bad++; $display("FAIL idle_flush_op got=%b result=%h exp=0/c", seen, bus.result); end
    endtask

    task automatic test_back_to_back;
        int e; logic g, bo;
        issue(3'b000, 32'd2, 32'd5, 32'd0, 32'd0);
        wait_done(e, g, bo);
        n_cmp++; if (g !== 1'b1 || bus.result !== 64'd10) begin n_bad++; $display("FAIL b2b_first got=%h exp=a", bus.result); end
        // still inside the done cycle: this start is sampled at the next edge
        bus.op_type = 3'b000; bus.a = 32'd3; bus.b = 32'hFFFF_FFFF; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
        wait_done(e, g, bo);
        n_cmp++; if (g !== 1'b1 || bus.result !== 64'h0000_0000_FFFF_FFFD) begin n_bad++; $display("FAIL b2b_second got=%h exp=00000000fffffffd", bus.result); end
    endtask

    task automatic test_reset_mid;
        int e; logic g, bo;
        issue(3'b100, 32'd1234, 32'hFFFF_FFFF, 32'd0, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        n_reset = 1'b0;
        #1;
        n_cmp++; if ({bus.result, bus.flag_n, bus.flag_z, bus.busy, bus.done} !== 68'd0) begin
            n_bad++; $display("FAIL reset_mid_outputs got=%h/%b%b%b%b exp=0", bus.result, bus.flag_n, bus.flag_z, bus.busy, bus.done);
        end
        @(negedge clk);
        n_reset = 1'b1;
        issue(3'b000, 32'd2, 32'd3, 32'd0, 32'd0);
        wait_done(e, g, bo);
`ifdef MUL_EARLY_TERM_EN
        n_cmp++; if (e != 2) begin n_bad++; $display("FAIL reset_mid_latency got=%0d exp=2", e); end
`else
        n_cmp++; if (e != 17) begin n_bad++; $display("FAIL reset_mid_latency got=%0d exp=17", e); end
`endif
        n_cmp++; if (bus.result !== 64'd6) begin n_bad++; $display("FAIL reset_mid_result got=%h exp=6", bus.result); end
    endtask

    task automatic test_early_term;
        int e; logic g, bo;
        issue(3'b000, 32'd5, 32'd1, 32'd0, 32'd0);
        wait_done(e, g, bo);
`ifdef MUL_EARLY_TERM_EN
        n_cmp++; if (e != 2) begin n_bad++; $display("FAIL early_short_latency got=%0d exp=2", e); end
`else
        n_cmp++; if (e != 17) begin n_bad++; $display("FAIL early_short_latency got=%0d exp=17", e); end
`endif
        n_cmp++; if (bus.result !== 64'd5) begin n_bad++; $display("FAIL early_short_result got=%h exp=5", bus.result); end
        issue(3'b100, 32'd5, 32'h8000_0000, 32'd0, 32'd0);
        wait_done(e, g, bo);
        n_cmp++; if (e != 17) begin n_bad++; $display("FAIL early_full_latency got=%0d exp=17", e); end
        n_cmp++; if (bus.result !== 64'h0000_0002_8000_0000) begin n_bad++; $display("FAIL early_full_result got=%h exp=0000000280000000", bus.result); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        n_reset = 1'b0;
        bus.start = 1'b0; bus.flush = 1'b0; bus.op_type = 3'b000;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
        test_reset;
        test_mul;
        test_long;
        test_accumulate;
        test_start_while_busy;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        test_early_term;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
